// File: rtl/mac_row_ctrl.sv
// rtl/mac_row_ctrl.sv - sequencer for one mac_row pass: kernel load, activation stream, drain
// Drives the array west edge and the read port of a 1-cycle-latency SRAM.

module mac_row_ctrl #(
    parameter int bw     = 4,
    parameter int col    = 8,
    parameter int row    = 8,
    parameter int addr_w = 11,
    parameter int len_w  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] base_w,
    input  logic [addr_w-1:0] base_x,
    input  logic [len_w-1:0]  n_vec,
    output logic              sram_cen,
    output logic [addr_w-1:0] sram_addr,
    input  logic [bw-1:0]     sram_dout,
    output logic [bw-1:0]     in_w,
    output logic [1:0]        inst_w,
    output logic              zero_flag,
    output logic              busy,
    output logic              done
);

    localparam int DRAIN_LEN = row + col;
    localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);
    localparam int KLOAD_W   = $clog2(col + 1);
    localparam int CNT_W0    = (len_w > DRAIN_W) ? len_w : DRAIN_W;
    localparam int CNT_W     = (CNT_W0 > KLOAD_W) ? CNT_W0 : KLOAD_W;

    localparam logic [1:0] ISSUE_NONE  = 2'b00;
    localparam logic [1:0] ISSUE_KLOAD = 2'b01;
    localparam logic [1:0] ISSUE_EXEC  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KLOAD,
        S_GAP,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [addr_w-1:0] addr_q, addr_d;
    logic [addr_w-1:0] base_x_q, base_x_d;
    logic [len_w-1:0]  n_q, n_d;
    logic [1:0]        inst_q, issue_d;
    logic              cen_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            base_x_q <= '0;
            n_q      <= '0;
            inst_q   <= ISSUE_NONE;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            base_x_q <= base_x_d;
            n_q      <= n_d;
            inst_q   <= issue_d;
        end
    end

    // The address register only moves on a read that is followed by another read,
    // so it naturally holds the last issued address whenever cen is low.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        base_x_d = base_x_q;
        n_d      = n_q;
        issue_d  = ISSUE_NONE;
        cen_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_KLOAD;
                    cnt_d    = CNT_W'(col - 1);
                    addr_d   = base_w;
                    base_x_d = base_x;
                    n_d      = n_vec;
                end
            end
            S_KLOAD: begin
                issue_d = ISSUE_KLOAD;
                cen_d   = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    addr_d = addr_q + addr_w'(1);
                end
            end
            S_GAP: begin
                if (n_q == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_LEN - 1);
                end else begin
                    state_d = S_EXEC;
                    cnt_d   = CNT_W'(n_q) - CNT_W'(1);
                    addr_d  = base_x_q;
                end
            end
            S_EXEC: begin
                issue_d = ISSUE_EXEC;
                cen_d   = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_LEN - 1);
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    addr_d = addr_q + addr_w'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // inst_w lags the issue code by the SRAM latency so it lines up with sram_dout.
    assign sram_cen  = cen_d;
    assign sram_addr = addr_q;
    assign in_w      = sram_dout;
    assign inst_w    = inst_q;
    assign zero_flag = inst_q[1] & (sram_dout == '0);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_mac_row_ctrl.sv
// tb/tb_mac_row_ctrl.sv - randomized self-checking bench for mac_row_ctrl against a per-cycle pass model
module tb_mac_row_ctrl;

    localparam int BW  = 4;
    localparam int COL = 8;
    localparam int ROW = 8;
    localparam int AW  = 11;
    localparam int LW  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_w;
    logic [AW-1:0] base_x;
    logic [LW-1:0] n_vec;
    logic          sram_cen;
    logic [AW-1:0] sram_addr;
    logic [BW-1:0] sram_dout = '0;
    logic [BW-1:0] in_w;
    logic [1:0]    inst_w;
    logic          zero_flag;
    logic          busy;
    logic          done;

    logic [BW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] last_addr;
    int            n_cmp = 0;
    int            n_bad = 0;

    mac_row_ctrl #(.bw(BW), .col(COL), .row(ROW), .addr_w(AW), .len_w(LW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .base_w(base_w), .base_x(base_x), .n_vec(n_vec),
        .sram_cen(sram_cen), .sram_addr(sram_addr), .sram_dout(sram_dout),
        .in_w(in_w), .inst_w(inst_w), .zero_flag(zero_flag),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_cen) sram_dout <= mem[sram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Phase of relative cycle c within a pass: 1 = weight read, 2 = activation read, 0 = neither.
    function automatic int phase(input int c, input int n);
        if (c >= 1 && c <= COL) return 1;
        if (c >= COL + 2 && c <= COL + 1 + n) return 2;
        return 0;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_cen"}, sram_cen, 0);
        check({tag, "_inst"}, inst_w, 0);
        check({tag, "_zf"}, zero_flag, 0);
        check({tag, "_addr"}, sram_addr, last_addr);
    endtask

    // Called at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
    task automatic run_pass(input logic [AW-1:0] wa, input logic [AW-1:0] xa, input int n,
                            input bit noise, input bit dstart, input int abort_at);
        int            len;
        int            ph;
        int            pph;
        logic [AW-1:0] exp_addr;
        logic [AW-1:0] prev_addr;
        logic [1:0]    exp_inst;
        logic [BW-1:0] exp_in;
        len = COL + 1 + n + ROW + COL + 1;
        check_idle("pre");
        start  = 1'b1;
        base_w = wa;
        base_x = xa;
        n_vec  = n[LW-1:0];
        prev_addr = last_addr;
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            start = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (noise) begin
                base_w = AW'($urandom);
                base_x = AW'($urandom);
                n_vec  = LW'($urandom);
            end
            if (c == len) start = dstart;
            ph  = phase(c, n);
            pph = phase(c - 1, n);
            if (ph == 1)      exp_addr = wa + AW'(c - 1);
            else if (ph == 2) exp_addr = xa + AW'(c - COL - 2);
            else              exp_addr = last_addr;
            exp_inst = (pph == 1) ? 2'b01 : (pph == 2) ? 2'b10 : 2'b00;
            exp_in   = mem[prev_addr];
            check("cen", sram_cen, (ph != 0));
            check("addr", sram_addr, exp_addr);
            check("inst", inst_w, exp_inst);
            check("busy", busy, 1);
            check("done", done, (c == len));
            check("zero_flag", zero_flag, (exp_inst == 2'b10) && (exp_in == '0));
            if (exp_inst != 2'b00) check("in_w", in_w, exp_in);
            last_addr = exp_addr;
            prev_addr = exp_addr;
            if (c == abort_at) begin
                start = 1'b0;
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                last_addr = '0;
                check_idle("abort");
                for (int k = 0; k < 40; k++) begin
                    @(negedge clk);
                    check("abort_nodone", done, 0);
                    check("abort_busy", busy, 0);
                end
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check_idle("post");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = BW'($urandom);
        reset  = 1'b1;
        start  = 1'b0;
        base_w = '0;
        base_x = '0;
        n_vec  = '0;
        last_addr = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("reset");
        end
        start  = 1'b1;
        base_w = AW'($urandom);
        n_vec  = 8'd5;
        @(negedge clk);
        check("reset_start_busy", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("after_reset");

        mem[11'h100] = 4'd3;
        mem[11'h101] = 4'd0;
        mem[11'h102] = 4'd5;
        mem[11'h103] = 4'd0;
        mem[11'h012] = 4'd0;
        mem[11'h015] = 4'd0;
        run_pass(11'h010, 11'h100, 4, 1'b0, 1'b0, 0);

        run_pass(11'h020, 11'h200, 0, 1'b0, 1'b0, 0);

        mem[11'h7FF] = 4'd0;
        run_pass(11'h030, 11'h7FE, 4, 1'b0, 1'b0, 0);

        run_pass(11'h040, 11'h300, 6, 1'b1, 1'b1, 0);
        run_pass(11'h050, 11'h310, 3, 1'b0, 1'b0, 0);

        run_pass(11'h060, 11'h400, 10, 1'b0, 1'b0, COL + 5);
        run_pass(11'h7FC, 11'h500, 2, 1'b0, 1'b0, 0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) mem[$urandom_range(0, (1 << AW) - 1)] = '0;
            run_pass(AW'($urandom), AW'($urandom), $urandom_range(0, 20),
                     1'($urandom), 1'($urandom), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
